lru_cache_ctrl: RTL and testbench
=================================

# lru_cache_ctrl

Parametrised fully-associative cache controller with true-LRU replacement, placed between a requester (CPU datapath/test harness) and a slower backing RAM. It generalises the fixed 4-line, 8-bit cache to configurable address width, data width and way count. It adds three capabilities: a ready/ack handshake to backing memory, write-through policy, and a single-cycle invalidate-all.

## Interface
Parameters:
- AW, 8, address width; the tag is the full address.
- DW, 8, data width.
- WAYS, 4, number of lines; power of two, ≥2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset; asynchronous, active-low.
- req  in  1  access request; level, sampled in IDLE.
- rw  in  1  1=write, 0=read.
- addr  in  AW  request address.
- wdata  in  DW  write data.
- inv  in  1  invalidate all lines; sampled in IDLE.
- rdata  out  DW  read result; valid when done=1.
- hit  out  1  1 if the access hit; valid when done=1.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high when not in IDLE.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_rw  out  1  1=write, 0=read.
- mem_addr  out  AW  backing-memory address.
- mem_wdata  out  DW  backing-memory write data.
- mem_rdata  in  DW  backing-memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge from memory.

## Operation
- States: IDLE, LOOKUP, FILL, WRITE.
- IDLE:
  - inv=1: clear all valid bits; req is ignored that edge.
  - else req=1: latch addr/wdata/rw, go to LOOKUP.
- LOOKUP: compare the latched address against all valid tags. At most one way matches.
  - Read hit: rdata ← line, hit ← 1, done ← 1, touch the way, go to IDLE.
  - Read miss: mem_req ← 1, mem_rw ← 0, mem_addr ← latched addr, go to FILL.
  - Write hit or miss: mem_req ← 1, mem_rw ← 1, mem_addr/mem_wdata ← latched values, go to WRITE.
    - On a hit, write the line data and touch the way in the same edge.
    - No allocate on a write miss.
- FILL: wait for mem_ack.
  - On ack, write mem_rdata into the victim way: set valid, set tag, touch the way.
  - Also on ack: rdata ← mem_rdata, hit ← 0, done ← 1, mem_req ← 0, go to IDLE.
- WRITE: wait for mem_ack.
  - On ack: done ← 1, hit ← the value recorded in LOOKUP, mem_req ← 0, go to IDLE.
- mem_ack outside FILL/WRITE is ignored.
- LRU: each way has a log2(WAYS)-bit age; 0 = MRU.
  - Touching way w of age a: every way with age < a increments; w ← 0.
  - Ages always form a permutation of 0..WAYS-1.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- inv clears valid bits only; ages are unchanged.
- req still high on the edge done is seen starts a new access. The requester drops req in the done cycle.

## Timing
- Reset (clr=0) forces, asynchronously:
  - state IDLE.
  - rdata, hit, done, busy, mem_req, mem_rw, mem_addr, mem_wdata all 0.
  - All valid bits 0; age[i]=i.
- Read hit: req sampled at edge N; done=1 after edge N+2, for one cycle.
- Miss/write: mem_req rises after edge N+2. If mem_ack is sampled at edge M, done=1 and mem_req=0 after edge M.
- mem_ack in the same cycle mem_req first rises is legal: zero-wait memory.
- busy=1 from edge N+1 until the edge that sets done.
- clr mid-operation: abort immediately.
  - No done pulse; mem_req drops asynchronously.
  - All lines become invalid.
  - A later mem_ack is ignored.

## Structure
- Package cache_pkg holds:
  - The state enum.
  - The LRU age-update and victim-select functions.
  - Localparam AGEW = $clog2(WAYS).
- Sub-module lru_age_tracker (WAYS) owns the age registers, with ports:
  - touch_en, touch_way (inputs).
  - valid vector (input).
  - victim_way (output).
- Remaining logic (tag/data/valid arrays, FSM) stays in lru_cache_ctrl. Target size is 150–300 lines.

## Test plan
- Cold read miss:
  - Stimulus: after reset, read 0x00.
  - Required: mem_req=1, mem_rw=0, mem_addr=0x00. Memory acks after 3 cycles with 0x80 → done=1, hit=0, rdata=0x80.
- Read hit:
  - Stimulus: read 0x00 again.
  - Required: done after edge N+2, hit=1, rdata=0x80, mem_req never asserted.
- Write-through, no allocate:
  - Stimulus: write 0x02←0xC0 (miss).
  - Required: mem_rw=1, mem_addr=0x02, mem_wdata=0xC0, done with hit=0. A following read of 0x02 misses.
- LRU eviction:
  - Stimulus: read-fill 0x10, 0x11, 0x12, 0x13; read 0x10 (hit); read 0x14 (miss).
  - Required: 0x14 replaces 0x11's way. Then read 0x11 misses and 0x10 hits.
- Invalidate:
  - Stimulus: assert inv=1 and req=1 together in IDLE.
  - Required: req ignored on that edge. The held req is accepted on the next edge, and read 0x10 then misses.
- Reset mid-operation:
  - Stimulus: drive clr=0 while in FILL awaiting ack.
  - Required: mem_req=0 immediately, no done pulse, a later ack is ignored, and a subsequent read of 0x00 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and LRU helpers for lru_cache_ctrl
// Purpose: controller state enum, age/victim helper functions and sizing constants.
// Ports: none (package).
package cache_pkg;

   // Default configuration and the widest configuration the helpers accept.
   localparam int WAYS_DFLT = 4;
   localparam int AGEW      = $clog2(WAYS_DFLT);
   localparam int MAX_WAYS  = 16;
   localparam int MAX_AGEW  = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_FILL,
      S_WRITE
   } state_t;

   typedef logic [MAX_AGEW-1:0] age_t;

   // New age of one way when way 'touched' (current age touched_age) becomes MRU.
   function automatic age_t lru_age_next(input age_t age, input age_t touched_age,
                                         input logic is_touched);
      if (is_touched)
         return '0;
      else if (age < touched_age)
         return age + age_t'(1);
      else
         return age;
   endfunction

   // Lowest-index invalid way; if every way is valid, the way holding the oldest age.
   function automatic age_t lru_victim(input logic [MAX_WAYS-1:0] valid,
                                       input logic [MAX_WAYS*MAX_AGEW-1:0] ages,
                                       input int ways);
      age_t v      = '0;
      age_t oldest = age_t'(ways - 1);
      for (int i = MAX_WAYS - 1; i >= 0; i--)
         if (i < ways && ages[i*MAX_AGEW +: MAX_AGEW] == oldest)
            v = age_t'(i);
      // Descending scan so the lowest invalid index is the one that sticks.
      for (int i = MAX_WAYS - 1; i >= 0; i--)
         if (i < ways && !valid[i])
            v = age_t'(i);
      return v;
   endfunction

endpackage

// File: rtl/lru_cache_ctrl_if.sv
// rtl/lru_cache_ctrl_if.sv - requester and backing-memory signal bundle
// Purpose: groups the request/response handshake and the backing-memory bus.
// Ports: master = requester plus memory model side, slave = cache controller side.
interface lru_cache_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req;
   logic          rw;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          inv;
   logic [DW-1:0] rdata;
   logic          hit;
   logic          done;
   logic          busy;
   logic          mem_req;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output req, rw, addr, wdata, inv, mem_rdata, mem_ack,
      input  rdata, hit, done, busy, mem_req, mem_rw, mem_addr, mem_wdata
   );

   modport slave (
      input  req, rw, addr, wdata, inv, mem_rdata, mem_ack,
      output rdata, hit, done, busy, mem_req, mem_rw, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lru_age_tracker.sv
// rtl/lru_age_tracker.sv - true-LRU age registers and victim selection
// Purpose: keeps one age per way (0 = MRU) as a permutation of 0..WAYS-1.
// Ports: clk, clr (async active-low), touch_en/touch_way (make a way MRU),
//        valid (line valid vector), victim_way (way to fill next).
module lru_age_tracker
   import cache_pkg::*;
#(
   parameter int WAYS = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    touch_en,
   input  logic [$clog2(WAYS)-1:0] touch_way,
   input  logic [WAYS-1:0]         valid,
   output logic [$clog2(WAYS)-1:0] victim_way
);
   localparam int AGW = $clog2(WAYS);

   logic [AGW-1:0]                age [WAYS];
   logic [MAX_WAYS-1:0]           valid_x;
   logic [MAX_WAYS*MAX_AGEW-1:0]  ages_x;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < WAYS; i++)
            age[i] <= AGW'(i);
      end else if (touch_en) begin
         for (int i = 0; i < WAYS; i++)
            age[i] <= AGW'(lru_age_next(age_t'(age[i]), age_t'(age[touch_way]),
                                        touch_way == AGW'(i)));
      end
   end

   // Widen to the helper's fixed shape; unused upper ways stay zero.
   always_comb begin
      valid_x             = '0;
      ages_x              = '0;
      valid_x[WAYS-1:0]   = valid;
      for (int i = 0; i < WAYS; i++)
         ages_x[i*MAX_AGEW +: MAX_AGEW] = age_t'(age[i]);
   end

   assign victim_way = AGW'(lru_victim(valid_x, ages_x, WAYS));

endmodule

// File: rtl/lru_cache_ctrl.sv
// rtl/lru_cache_ctrl.sv - fully-associative write-through cache controller with true LRU
// Purpose: serves reads from WAYS lines tagged by full address, fills on read miss,
//          writes through to memory without allocating, single-cycle invalidate-all.
// Ports: clk, clr (async active-low reset), bus (slave side of lru_cache_ctrl_if).
module lru_cache_ctrl
   import cache_pkg::*;
#(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int WAYS = 4
) (
   input  logic            clk,
   input  logic            clr,
   lru_cache_ctrl_if.slave bus
);
   localparam int WW = $clog2(WAYS);

   state_t          state, state_n;

   logic [AW-1:0]   a_q;
   logic [DW-1:0]   d_q;
   logic            rw_q;
   logic            hit_rec, hit_rec_n;

   logic [AW-1:0]   tag  [WAYS];
   logic [DW-1:0]   line [WAYS];
   logic [WAYS-1:0] valid;

   logic [DW-1:0]   rdata_q, rdata_n;
   logic            hit_q, hit_n;
   logic            done_q, done_n;
   logic            mreq_q, mreq_n;
   logic            mrw_q, mrw_n;
   logic [AW-1:0]   maddr_q, maddr_n;
   logic [DW-1:0]   mwd_q, mwd_n;

   logic            lat_en, inv_all, line_we, fill_we, touch_en;
   logic [WW-1:0]   touch_way, victim_way, match_way;
   logic            match;

   lru_age_tracker #(.WAYS(WAYS)) u_age (
      .clk        (clk),
      .clr        (clr),
      .touch_en   (touch_en),
      .touch_way  (touch_way),
      .valid      (valid),
      .victim_way (victim_way)
   );

   always_comb begin
      match     = 1'b0;
      match_way = '0;
      for (int i = 0; i < WAYS; i++)
         if (valid[i] && tag[i] == a_q) begin
            match     = 1'b1;
            match_way = WW'(i);
         end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= S_IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n   = state;
      rdata_n   = rdata_q;
      hit_n     = hit_q;
      done_n    = 1'b0;
      mreq_n    = mreq_q;
      mrw_n     = mrw_q;
      maddr_n   = maddr_q;
      mwd_n     = mwd_q;
      hit_rec_n = hit_rec;
      lat_en    = 1'b0;
      inv_all   = 1'b0;
      line_we   = 1'b0;
      fill_we   = 1'b0;
      touch_en  = 1'b0;
      touch_way = match_way;
      case (state)
         S_IDLE: begin
            if (bus.inv)
               inv_all = 1'b1;
            else if (bus.req) begin
               lat_en  = 1'b1;
               state_n = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (!rw_q) begin
               if (match) begin
                  rdata_n  = line[match_way];
                  hit_n    = 1'b1;
                  done_n   = 1'b1;
                  touch_en = 1'b1;
                  state_n  = S_IDLE;
               end else begin
                  mreq_n  = 1'b1;
                  mrw_n   = 1'b0;
                  maddr_n = a_q;
                  state_n = S_FILL;
               end
            end else begin
               // Write-through: memory always sees the write; a hit also updates the line.
               mreq_n    = 1'b1;
               mrw_n     = 1'b1;
               maddr_n   = a_q;
               mwd_n     = d_q;
               hit_rec_n = match;
               line_we   = match;
               touch_en  = match;
               state_n   = S_WRITE;
            end
         end
         S_FILL: begin
            if (bus.mem_ack) begin
               fill_we   = 1'b1;
               touch_en  = 1'b1;
               touch_way = victim_way;
               rdata_n   = bus.mem_rdata;
               hit_n     = 1'b0;
               done_n    = 1'b1;
               mreq_n    = 1'b0;
               state_n   = S_IDLE;
            end
         end
         S_WRITE: begin
            if (bus.mem_ack) begin
               hit_n   = hit_rec;
               done_n  = 1'b1;
               mreq_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         a_q     <= '0;
         d_q     <= '0;
         rw_q    <= 1'b0;
         hit_rec <= 1'b0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
         done_q  <= 1'b0;
         mreq_q  <= 1'b0;
         mrw_q   <= 1'b0;
         maddr_q <= '0;
         mwd_q   <= '0;
      end else begin
         if (lat_en) begin
            a_q  <= bus.addr;
            d_q  <= bus.wdata;
            rw_q <= bus.rw;
         end
         hit_rec <= hit_rec_n;
         rdata_q <= rdata_n;
         hit_q   <= hit_n;
         done_q  <= done_n;
         mreq_q  <= mreq_n;
         mrw_q   <= mrw_n;
         maddr_q <= maddr_n;
         mwd_q   <= mwd_n;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         valid <= '0;
      else if (inv_all)
         valid <= '0;
      else if (fill_we)
         valid[victim_way] <= 1'b1;
   end

   // Tag and data contents are meaningless while invalid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag[victim_way]  <= a_q;
         line[victim_way] <= bus.mem_rdata;
      end else if (line_we) begin
         line[match_way] <= d_q;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.hit       = hit_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.mem_req   = mreq_q;
   assign bus.mem_rw    = mrw_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = mwd_q;

endmodule

// File: tb/tb_lru_cache_ctrl.sv
// tb/tb_lru_cache_ctrl.sv - directed vector bench for lru_cache_ctrl
module tb_lru_cache_ctrl;

   logic clk;
   logic clr;
   int   total = 0;
   int   bad   = 0;

   lru_cache_ctrl_if #(.AW(8), .DW(8)) bus ();

   lru_cache_ctrl #(.AW(8), .DW(8), .WAYS(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      int         dly;
      logic [7:0] md;
      logic       pre_inv;
      logic       e_hit;
      logic [7:0] e_rdata;
      logic       e_mem;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [7:0] d,
                               input int dly, input logic [7:0] md, input logic pre_inv,
                               input logic e_hit, input logic [7:0] e_rdata, input logic e_mem);
      vec_t v;
      v.w = w; v.a = a; v.d = d; v.dly = dly; v.md = md; v.pre_inv = pre_inv;
      v.e_hit = e_hit; v.e_rdata = e_rdata; v.e_mem = e_mem;
      return v;
   endfunction

   // Drives one access and acts as the backing memory, acking dly cycles after mem_req.
   task automatic run_access(input vec_t v, output int done_cyc, output logic g_hit,
                             output logic [7:0] g_rdata, output logic g_mem,
                             output logic g_mrw, output logic [7:0] g_maddr,
                             output logic [7:0] g_mwd, output logic g_busy1,
                             output logic g_mreq_done, output logic g_done2);
      int cyc;
      int ack_cnt;
      bit acked;
      done_cyc = -1; g_hit = 1'bx; g_rdata = 'x; g_mem = 1'b0; g_mrw = 1'b0;
      g_maddr = '0; g_mwd = '0; g_busy1 = 1'b0; g_mreq_done = 1'b1; g_done2 = 1'b1;
      @(negedge clk);
      bus.req = 1'b1; bus.rw = v.w; bus.addr = v.a; bus.wdata = v.d;
      if (v.pre_inv) begin
         bus.inv = 1'b1;
         @(negedge clk);
         bus.inv = 1'b0;
         chk($sformatf("inv_edge_ignores_req_busy a=%0h", v.a), bus.busy, 0);
      end
      cyc = 0; ack_cnt = 0; acked = 0;
      while (done_cyc < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.mem_ack = 1'b0;
         if (cyc == 1) g_busy1 = bus.busy;
         if (bus.done) begin
            done_cyc    = cyc;
            g_hit       = bus.hit;
            g_rdata     = bus.rdata;
            g_mreq_done = bus.mem_req;
            bus.req     = 1'b0;
         end else if (bus.mem_req && !acked) begin
            if (!g_mem) begin
               g_mem = 1'b1; g_mrw = bus.mem_rw; g_maddr = bus.mem_addr; g_mwd = bus.mem_wdata;
            end
            if (ack_cnt == v.dly) begin
               bus.mem_ack = 1'b1; bus.mem_rdata = v.md; acked = 1;
            end else
               ack_cnt++;
         end
      end
      bus.req = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      g_done2 = bus.done;
   endtask

   task automatic check_vec(input int k, input vec_t v);
      int dc;
      logic h, m, mrw, b1, mrd, d2;
      logic [7:0] rd, ma, mw;
      string tg;
      tg = $sformatf("v%0d a=%0h", k, v.a);
      run_access(v, dc, h, rd, m, mrw, ma, mw, b1, mrd, d2);
      chk({tg, " done_cycle"}, dc, v.e_mem ? 3 + v.dly : 2);
      chk({tg, " hit"}, h, v.e_hit);
      if (!v.w) chk({tg, " rdata"}, rd, v.e_rdata);
      chk({tg, " mem_req_seen"}, m, v.e_mem);
      if (v.e_mem) begin
         chk({tg, " mem_rw"}, mrw, v.w);
         chk({tg, " mem_addr"}, ma, v.a);
         if (v.w) chk({tg, " mem_wdata"}, mw, v.d);
      end
      chk({tg, " busy_after_accept"}, b1, 1);
      chk({tg, " mem_req_low_at_done"}, mrd, 0);
      chk({tg, " done_one_cycle"}, d2, 0);
   endtask

   initial begin
      int n;
      clr = 1'b0;
      bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.inv = 1'b0;
      bus.mem_rdata = '0; bus.mem_ack = 1'b0;

      //            w  addr   wdata dly md     inv hit rdata mem
      vecs.push_back(mk(0, 8'h00, 8'h00, 3, 8'h80, 0, 0, 8'h80, 1)); // cold miss
      vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h80, 0)); // hit
      vecs.push_back(mk(1, 8'h02, 8'hC0, 1, 8'h00, 0, 0, 8'h00, 1)); // write miss
      vecs.push_back(mk(0, 8'h02, 8'h00, 0, 8'h22, 0, 0, 8'h22, 1)); // no allocate, zero-wait
      vecs.push_back(mk(0, 8'h10, 8'h00, 1, 8'hA0, 0, 0, 8'hA0, 1));
      vecs.push_back(mk(0, 8'h11, 8'h00, 2, 8'hA1, 0, 0, 8'hA1, 1));
      vecs.push_back(mk(0, 8'h12, 8'h00, 0, 8'hA2, 0, 0, 8'hA2, 1)); // evicts 0x00
      vecs.push_back(mk(0, 8'h13, 8'h00, 1, 8'hA3, 0, 0, 8'hA3, 1)); // evicts 0x02
      vecs.push_back(mk(0, 8'h10, 8'h00, 0, 8'h00, 0, 1, 8'hA0, 0));
      vecs.push_back(mk(0, 8'h14, 8'h00, 1, 8'hA4, 0, 0, 8'hA4, 1)); // evicts 0x11
      vecs.push_back(mk(0, 8'h11, 8'h00, 1, 8'hB1, 0, 0, 8'hB1, 1)); // evicts 0x12
      vecs.push_back(mk(0, 8'h10, 8'h00, 0, 8'h00, 0, 1, 8'hA0, 0));
      vecs.push_back(mk(0, 8'h14, 8'h00, 0, 8'h00, 0, 1, 8'hA4, 0));
      vecs.push_back(mk(1, 8'h13, 8'h5A, 2, 8'h00, 0, 1, 8'h00, 1)); // write hit
      vecs.push_back(mk(0, 8'h13, 8'h00, 0, 8'h00, 0, 1, 8'h5A, 0));
      vecs.push_back(mk(0, 8'h10, 8'h00, 1, 8'hC5, 1, 0, 8'hC5, 1)); // inv + req
      vecs.push_back(mk(0, 8'h10, 8'h00, 0, 8'h00, 0, 1, 8'hC5, 0));

      repeat (2) @(negedge clk);
      chk("reset rdata", bus.rdata, 0);
      chk("reset hit", bus.hit, 0);
      chk("reset done", bus.done, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset mem_req", bus.mem_req, 0);
      chk("reset mem_rw", bus.mem_rw, 0);
      chk("reset mem_addr", bus.mem_addr, 0);
      chk("reset mem_wdata", bus.mem_wdata, 0);
      clr = 1'b1;

      for (int k = 0; k < vecs.size(); k++)
         check_vec(k, vecs[k]);

      // Reset while a fill is waiting for its acknowledge.
      @(negedge clk);
      bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 8'h00;
      n = 0;
      while (!bus.mem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midreset reached_fill", bus.mem_req, 1);
      bus.req = 1'b0;
      #2 clr = 1'b0;
      #1;
      chk("midreset mem_req_async", bus.mem_req, 0);
      chk("midreset busy", bus.busy, 0);
      chk("midreset done", bus.done, 0);
      @(negedge clk);
      clr = 1'b1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("late_ack done", bus.done, 0);
      chk("late_ack busy", bus.busy, 0);
      chk("late_ack mem_req", bus.mem_req, 0);
      @(negedge clk);
      chk("late_ack done_later", bus.done, 0);
      check_vec(100, mk(0, 8'h00, 8'h00, 1, 8'h3C, 0, 0, 8'h3C, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
